reg_file_gen: RTL and testbench



---
 rtl/reg_file_gen.sv | 102 ++++++++++
 tb/tb_reg_file_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_gen.sv
// Two-read/one-write register file that zeroes itself with a DEPTH-cycle sweep after reset or clr.
// Define REGFILE_BYPASS_EN to forward a same-cycle qualifying write to the read ports.
module reg_file_gen #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 8,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             ready
);

  localparam logic [AW:0] DepthW  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LastIdx = (AW+1)'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e           state_q, state_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wrEn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) state_d = READY;
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // A write needs READY, an in-range address, and not the hardwired zero register.
  assign wrEn = (state_q == READY) && we3 && ({1'b0, wa3} < DepthW) &&
                !((ZERO_REG != 0) && (wa3 == '0));

  // The clr edge itself still lets a qualifying write land; the sweep then zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[cnt_q[AW-1:0]] <= '0;
      end else if (wrEn) begin
        mem_q[wa3] <= wd3;
      end
    end
  end

  function automatic logic [WIDTH-1:0] readPort(input logic [AW-1:0] ra);
    logic [WIDTH-1:0] v;
    v = '0;
    if ((state_q == READY) && ({1'b0, ra} < DepthW) && !((ZERO_REG != 0) && (ra == '0))) begin
`ifdef REGFILE_BYPASS_EN
      if (wrEn && (ra == wa3)) begin
        v = wd3;
      end else begin
        v = mem_q[ra];
      end
`else
      v = mem_q[ra];
`endif
    end
    return v;
  endfunction

  always_comb begin
    rd1 = readPort(ra1);
    rd2 = readPort(ra2);
  end

  assign ready = (state_q == READY);

endmodule

// File: tb/tb_reg_file_gen.sv
// Self-checking bench: default, DEPTH=6 and ZERO_REG=1 instances share one stimulus stream.
// Vector table with a scoreboard queue, plus hand-written sweep, bypass and reset sequences.
module tb_reg_file_gen;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, clr, we3;
  logic [2:0] wa3, ra1, ra2;
  logic [7:0] wd3;
  logic [7:0] rdA1, rdA2, rdB1, rdB2, rdZ1, rdZ2;
  logic       readyA, readyB, readyZ;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  reg_file_gen #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) dutA (
    .clk(clk), .rst(rst), .clr(clr), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rdA1), .rd2(rdA2), .ready(readyA));

  reg_file_gen #(.WIDTH(8), .DEPTH(6), .ZERO_REG(0)) dutB (
    .clk(clk), .rst(rst), .clr(clr), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rdB1), .rd2(rdB2), .ready(readyB));

  reg_file_gen #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) dutZ (
    .clk(clk), .rst(rst), .clr(clr), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rdZ1), .rd2(rdZ2), .ready(readyZ));

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [7:0] eA1, eA2, eB1, eB2, eZ1, eZ2;
  } vec_t;

  vec_t vecs[6];
  vec_t sbq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                               input logic [2:0] r1, input logic [2:0] r2);
    we3 = we;
    wa3 = wa;
    wd3 = wd;
    ra1 = r1;
    ra2 = r2;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t cur;
    vec_t exp;

    //           we    wa    wd     r1    r2    eA1    eA2    eB1    eB2    eZ1    eZ2
    vecs[0] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd3, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{1'b0, 3'd4, 8'h00, 3'd4, 3'd3, 8'h00, 8'hA5, 8'h00, 8'hA5, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 3'd7, 8'h5A, 3'd7, 3'd6, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00};
    vecs[3] = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd1, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 3'd1, 8'hFF, 3'd0, 3'd1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    vecs[5] = '{1'b1, 3'd5, 8'h11, 3'd5, 3'd7, 8'h11, 8'h5A, 8'h11, 8'h00, 8'h11, 8'h5A};

    rst = 1'b1;
    clr = 1'b0;
    applyStimulus(1'b1, 3'd2, 8'h42, 3'd0, 3'd0);
    tick();
    checkOutput("reset readyA", {7'd0, readyA}, 8'd0);
    checkOutput("reset readyB", {7'd0, readyB}, 8'd0);
    checkOutput("reset readyZ", {7'd0, readyZ}, 8'd0);
    checkOutput("reset rdA1", rdA1, 8'h00);
    checkOutput("reset rdA2", rdA2, 8'h00);
    rst = 1'b0;
    we3 = 1'b0;

    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput($sformatf("init sweep readyA edge %0d", i), {7'd0, readyA}, {7'd0, i == 8});
      checkOutput($sformatf("init sweep readyB edge %0d", i), {7'd0, readyB}, {7'd0, i >= 6});
      checkOutput($sformatf("init sweep readyZ edge %0d", i), {7'd0, readyZ}, {7'd0, i == 8});
    end

    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b0, 3'd0, 8'h00, 3'(a), 3'(7 - a));
      #1;
      checkOutput($sformatf("post-reset A rd1 addr %0d", a), rdA1, 8'h00);
      checkOutput($sformatf("post-reset A rd2 addr %0d", 7 - a), rdA2, 8'h00);
    end

    for (int k = 0; k < 6; k++) begin
      cur = vecs[k];
      applyStimulus(cur.we, cur.wa, cur.wd, 3'd0, 3'd0);
      sbq.push_back(cur);
      tick();
      applyStimulus(1'b0, 3'd0, 8'h00, cur.r1, cur.r2);
      #1;
      exp = sbq.pop_front();
      checkOutput($sformatf("vec%0d A rd1", k), rdA1, exp.eA1);
      checkOutput($sformatf("vec%0d A rd2", k), rdA2, exp.eA2);
      checkOutput($sformatf("vec%0d B rd1", k), rdB1, exp.eB1);
      checkOutput($sformatf("vec%0d B rd2", k), rdB2, exp.eB2);
      checkOutput($sformatf("vec%0d Z rd1", k), rdZ1, exp.eZ1);
      checkOutput($sformatf("vec%0d Z rd2", k), rdZ2, exp.eZ2);
    end
    checkOutput("B ready after out-of-range writes", {7'd0, readyB}, 8'd1);

    applyStimulus(1'b1, 3'd2, 8'h77, 3'd0, 3'd0);
    tick();
    applyStimulus(1'b1, 3'd2, 8'h3C, 3'd2, 3'd2);
    #1;
    checkOutput("same-cycle read A rd1", rdA1, Bypass ? 8'h3C : 8'h77);
    checkOutput("same-cycle read Z rd2", rdZ2, Bypass ? 8'h3C : 8'h77);
    tick();
    we3 = 1'b0;
    #1;
    checkOutput("after write A rd1", rdA1, 8'h3C);
    applyStimulus(1'b1, 3'd0, 8'hEE, 3'd0, 3'd0);
    #1;
    checkOutput("same-cycle reg0 A rd1", rdA1, Bypass ? 8'hEE : 8'hFF);
    checkOutput("same-cycle reg0 Z rd1", rdZ1, 8'h00);
    we3 = 1'b0;

    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b1, 3'(a), 8'(8'h10 + a), 3'd0, 3'd0);
      tick();
    end
    applyStimulus(1'b0, 3'd0, 8'h00, 3'd6, 3'd3);
    #1;
    checkOutput("fill A reg6", rdA1, 8'h16);
    checkOutput("fill A reg3", rdA2, 8'h13);

    // clr and a write on the same edge; we3 then held high through the sweep.
    clr = 1'b1;
    applyStimulus(1'b1, 3'd3, 8'h99, 3'd3, 3'd3);
    tick();
    clr = 1'b0;
    checkOutput("clr edge readyA", {7'd0, readyA}, 8'd0);
    checkOutput("clearing A rd1", rdA1, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      clr = (i == 3);
      applyStimulus(1'b1, 3'(i), 8'(8'hC0 + i), 3'd3, 3'd3);
      tick();
      checkOutput($sformatf("clr sweep readyA edge %0d", i), {7'd0, readyA}, {7'd0, i == 8});
      checkOutput($sformatf("clr sweep readyB edge %0d", i), {7'd0, readyB}, {7'd0, i >= 6});
    end
    clr = 1'b0;
    we3 = 1'b0;
    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b0, 3'd0, 8'h00, 3'(a), 3'(a));
      #1;
      checkOutput($sformatf("cleared A addr %0d", a), rdA1, 8'h00);
      checkOutput($sformatf("cleared Z addr %0d", a), rdZ2, 8'h00);
    end
    ra1 = 3'd0;
    #1;
    checkOutput("B reg0 written after its shorter sweep", rdB1, 8'hC8);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput($sformatf("pre-abort readyA edge %0d", i), {7'd0, readyA}, 8'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid-sweep rst readyA", {7'd0, readyA}, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput($sformatf("restart readyA edge %0d", i), {7'd0, readyA}, {7'd0, i == 8});
      checkOutput($sformatf("restart readyB edge %0d", i), {7'd0, readyB}, {7'd0, i >= 6});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
